// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust controller for a stopwatch time counter.
// Ports:
//   clk_sel      system clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   pause_btn    raw bouncing pause button, synchronized and debounced here
//   adj_sw       raw adjust-mode switch (1 = adjust)
//   sel_sw       raw adjust-target switch (1 = seconds, 0 = minutes)
//   tick_1hz     1 Hz single-cycle enable, counts time while running
//   tick_2hz     2 Hz single-cycle enable, steps the selected field while adjusting
//   inc_strobe   registered single-cycle increment command
//   inc_mode     00 cascade, 01 minutes only, 10 seconds only
//   paused       high while in PAUSE
//   digit_blank  {min_10s, min_1s, sec_10s, sec_1s} blank mask
// Build option: define STOPWATCH_BLINK_EN to blink the field being adjusted;
// otherwise digit_blank is tied to 0000.
module stopwatch_ctrl #(
  parameter int DEB_MAX = 50000
) (
  input  logic       clk_sel,
  input  logic       rst,
  input  logic       pause_btn,
  input  logic       adj_sw,
  input  logic       sel_sw,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  output logic       inc_strobe,
  output logic [1:0] inc_mode,
  output logic       paused,
  output logic [3:0] digit_blank
);
  typedef enum logic [1:0] {RUN, PAUSE, ADJ} state_t;
  logic [1:0] pb_q, adj_q, sel_q;
  logic pb_s, adj_s, sel_s;
  logic [16:0] cnt_q;
  logic deb_q, pp_q, accept;
  state_t state_q, state_d, ret_q, ret_d;
  logic strobe_q, paused_q;
  logic [1:0] mode_q;
  assign pb_s = pb_q[1];
  assign adj_s = adj_q[1];
  assign sel_s = sel_q[1];
  // the DEB_MAX-th consecutive cycle with pb_s differing from the accepted level
  assign accept = (pb_s != deb_q) && (cnt_q == 17'(DEB_MAX - 1));
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    if (state_q == ADJ) begin
      if (!adj_s) state_d = ret_q;
    end else if (adj_s) begin
      state_d = ADJ;
      ret_d = state_q;
    end else if (pp_q) begin
      state_d = (state_q == RUN) ? PAUSE : RUN;
    end
  end
  always_ff @(posedge clk_sel or posedge rst) begin
    if (rst) begin
      pb_q <= '0;
      adj_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      deb_q <= 1'b0;
      pp_q <= 1'b0;
      state_q <= RUN;
      ret_q <= RUN;
      strobe_q <= 1'b0;
      mode_q <= 2'b00;
      paused_q <= 1'b0;
    end else begin
      pb_q <= {pb_q[0], pause_btn};
      adj_q <= {adj_q[0], adj_sw};
      sel_q <= {sel_q[0], sel_sw};
      cnt_q <= (pb_s == deb_q || accept) ? '0 : cnt_q + 17'd1;
      deb_q <= accept ? pb_s : deb_q;
      pp_q <= accept && pb_s;
      state_q <= state_d;
      ret_q <= ret_d;
      strobe_q <= (state_q == RUN && tick_1hz) || (state_q == ADJ && tick_2hz);
      mode_q <= (state_q != ADJ) ? 2'b00 : sel_s ? 2'b10 : 2'b01;
      paused_q <= state_d == PAUSE;
    end
  end
  assign inc_strobe = strobe_q;
  assign inc_mode = mode_q;
  assign paused = paused_q;
`ifdef STOPWATCH_BLINK_EN
  logic phase_q;
  logic [3:0] blank_q;
  always_ff @(posedge clk_sel or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      blank_q <= 4'b0000;
    end else begin
      phase_q <= (state_q == ADJ) && (phase_q ^ tick_2hz);
      blank_q <= !phase_q ? 4'b0000 : sel_s ? 4'b0011 : 4'b1100;
    end
  end
  assign digit_blank = blank_q;
`else
  assign digit_blank = 4'b0000;
`endif
endmodule
